// File: rtl/cms_pkg.sv
// Shared types, parameter defaults and the saturating-increment helper
// for the count-min sketch row bank.
package cms_pkg;

    localparam int CMS_NUM_ROWS_DEF = 4;
    localparam int CMS_COLS_DEF     = 4096;
    localparam int CMS_CNT_SIZE_DEF = 32;
    localparam int CMS_EPOCH_W_DEF  = 4;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        SWEEP
    } cms_state_e;

    typedef enum logic {
        CMS_UPDATE = 1'b0,
        CMS_QUERY  = 1'b1
    } cms_op_e;

    // Increment v and hold at the all-ones value of a w-bit counter (1 <= w <= 64).
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
        logic [63:0] max_v;
        max_v = {64{1'b1}} >> (64 - w);
        return (v == max_v) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/cms_row.sv
// One sketch row: {epoch tag, count} RAM with read-first read port and one write
// port, forwarding of the previous cycle's write, and the saturating update.
module cms_row
    import cms_pkg::*;
#(
    parameter int COLS     = CMS_COLS_DEF,
    parameter int CNT_SIZE = CMS_CNT_SIZE_DEF,
    parameter int EPOCH_W  = CMS_EPOCH_W_DEF,
    parameter int COL_W    = $clog2(COLS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [COL_W-1:0]    s0_col,
    input  logic                s1_upd,
    input  logic [EPOCH_W-1:0]  epoch,
    input  logic                sweep_en,
    input  logic [COL_W-1:0]    sweep_col,
    output logic [CNT_SIZE-1:0] res_cnt
);

    localparam int ENT_W = EPOCH_W + CNT_SIZE;

    logic [ENT_W-1:0]    mem_q [COLS];
    logic [ENT_W-1:0]    rd_q;

    logic [COL_W-1:0]    s1_col_q, s1_col_d;
    logic                s3_wr_q,  s3_wr_d;
    logic [COL_W-1:0]    s3_col_q, s3_col_d;
    logic [ENT_W-1:0]    s3_ent_q, s3_ent_d;

    logic                wr_en;
    logic [COL_W-1:0]    wr_col;
    logic [ENT_W-1:0]    wr_ent;
    logic [ENT_W-1:0]    cur_ent;
    logic [ENT_W-1:0]    new_ent;
    logic [CNT_SIZE-1:0] cur_cnt;
    logic [CNT_SIZE-1:0] new_cnt;

    // Non-blocking read and write on the same edge give read-first behaviour.
    always_ff @(posedge clk) begin
        rd_q <= mem_q[s0_col];
        if (wr_en) begin
            mem_q[wr_col] <= wr_ent;
        end
    end

    always_comb begin
        // The read for the entry now in S1 was issued while the previous
        // request was being written, so that write must be forwarded.
        cur_ent = rd_q;
        if (s3_wr_q && (s3_col_q == s1_col_q)) begin
            cur_ent = s3_ent_q;
        end

        cur_cnt = (cur_ent[ENT_W-1 -: EPOCH_W] == epoch) ? cur_ent[CNT_SIZE-1:0] : '0;
        new_cnt = CNT_SIZE'(sat_inc(64'(cur_cnt), CNT_SIZE));
        new_ent = {epoch, new_cnt};
        res_cnt = s1_upd ? new_cnt : cur_cnt;

        wr_en  = sweep_en || s1_upd;
        wr_col = sweep_en ? sweep_col : s1_col_q;
        wr_ent = sweep_en ? '0 : new_ent;

        s1_col_d = s0_col;
        s3_wr_d  = s1_upd && !sweep_en;
        s3_col_d = s1_col_q;
        s3_ent_d = new_ent;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s3_wr_q <= 1'b0;
        end else begin
            s3_wr_q <= s3_wr_d;
        end
    end

    always_ff @(posedge clk) begin
        s1_col_q <= s1_col_d;
        s3_col_q <= s3_col_d;
        s3_ent_q <= s3_ent_d;
    end

endmodule

// File: rtl/cms_row_bank.sv
// Count-min sketch row bank: NUM_ROWS counter rows, epoch-tag clear, sweep on wrap.
// Optional min-over-rows output enabled by defining CMS_MIN_REDUCE_EN.
//
//  state | meaning
//  RUN   | accepting requests
//  DRAIN | clear pending, waiting for S0/S1 to empty before bumping epoch
//  SWEEP | epoch wrapped; writing {tag 0, cnt 0} to every column of every row
module cms_row_bank
    import cms_pkg::*;
#(
    parameter int NUM_ROWS = CMS_NUM_ROWS_DEF,
    parameter int COLS     = CMS_COLS_DEF,
    parameter int CNT_SIZE = CMS_CNT_SIZE_DEF,
    parameter int EPOCH_W  = CMS_EPOCH_W_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               in_op,
    input  logic [NUM_ROWS*$clog2(COLS)-1:0]   in_col,
    input  logic                               clr_req,
    output logic                               clr_busy,
    output logic                               out_valid,
    output logic                               out_op,
    output logic [NUM_ROWS*CNT_SIZE-1:0]       out_cnt,
    output logic [CNT_SIZE-1:0]                out_min
);

    localparam int COL_W = $clog2(COLS);

    cms_state_e                    state_q, state_d;
    logic [EPOCH_W-1:0]            epoch_q, epoch_d;
    logic [COL_W-1:0]              sweep_cnt_q, sweep_cnt_d;

    logic                          s0_valid_q, s0_valid_d;
    cms_op_e                       s0_op_q, s0_op_d;
    logic [NUM_ROWS*COL_W-1:0]     s0_col_q, s0_col_d;
    logic                          s1_valid_q, s1_valid_d;
    cms_op_e                       s1_op_q, s1_op_d;

    logic                          out_valid_q, out_valid_d;
    cms_op_e                       out_op_q, out_op_d;
    logic [NUM_ROWS*CNT_SIZE-1:0]  out_cnt_q, out_cnt_d;
    logic [CNT_SIZE-1:0]           out_min_q, out_min_d;

    logic                          accept;
    logic                          s1_upd;
    logic                          sweep_en;
    logic [NUM_ROWS*CNT_SIZE-1:0]  res_cnt;
    logic [CNT_SIZE-1:0]           min_res;

    assign in_ready  = (state_q == RUN) && !rst;
    assign clr_busy  = (state_q != RUN) && !rst;
    assign accept    = in_valid && in_ready;
    assign s1_upd    = s1_valid_q && (s1_op_q == CMS_UPDATE);
    assign sweep_en  = (state_q == SWEEP);

    assign out_valid = out_valid_q;
    assign out_op    = out_op_q;
    assign out_cnt   = out_cnt_q;
    assign out_min   = out_min_q;

    always_comb begin
        state_d     = state_q;
        epoch_d     = epoch_q;
        sweep_cnt_d = sweep_cnt_q;
        case (state_q)
            RUN: begin
                if (clr_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!s0_valid_q && !s1_valid_q) begin
                    epoch_d = epoch_q + 1'b1;
                    if (epoch_d == '0) begin
                        state_d     = SWEEP;
                        sweep_cnt_d = COL_W'(COLS - 1);
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            SWEEP: begin
                if (sweep_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    sweep_cnt_d = sweep_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = SWEEP;
            end
        endcase
    end

    always_comb begin
        s0_valid_d  = accept;
        s0_op_d     = accept ? cms_op_e'(in_op) : s0_op_q;
        s0_col_d    = accept ? in_col : s0_col_q;
        s1_valid_d  = s0_valid_q;
        s1_op_d     = s0_op_q;
        out_valid_d = s1_valid_q;
        out_op_d    = s1_valid_q ? s1_op_q : out_op_q;
        out_cnt_d   = s1_valid_q ? res_cnt : out_cnt_q;
        out_min_d   = s1_valid_q ? min_res : out_min_q;
    end

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        cms_row #(
            .COLS     (COLS),
            .CNT_SIZE (CNT_SIZE),
            .EPOCH_W  (EPOCH_W),
            .COL_W    (COL_W)
        ) u_row (
            .clk       (clk),
            .rst       (rst),
            .s0_col    (s0_col_q[r*COL_W +: COL_W]),
            .s1_upd    (s1_upd),
            .epoch     (epoch_q),
            .sweep_en  (sweep_en),
            .sweep_col (sweep_cnt_q),
            .res_cnt   (res_cnt[r*CNT_SIZE +: CNT_SIZE])
        );
    end

`ifdef CMS_MIN_REDUCE_EN
    always_comb begin
        min_res = res_cnt[CNT_SIZE-1:0];
        for (int r = 1; r < NUM_ROWS; r++) begin
            if (res_cnt[r*CNT_SIZE +: CNT_SIZE] < min_res) begin
                min_res = res_cnt[r*CNT_SIZE +: CNT_SIZE];
            end
        end
    end
`else
    assign min_res = '0;
`endif

    // Reset re-runs the sweep so no entry from before reset can hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SWEEP;
            epoch_q     <= '0;
            sweep_cnt_q <= COL_W'(COLS - 1);
            s0_valid_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_op_q    <= CMS_UPDATE;
            out_cnt_q   <= '0;
            out_min_q   <= '0;
        end else begin
            state_q     <= state_d;
            epoch_q     <= epoch_d;
            sweep_cnt_q <= sweep_cnt_d;
            s0_valid_q  <= s0_valid_d;
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            out_cnt_q   <= out_cnt_d;
            out_min_q   <= out_min_d;
        end
    end

    always_ff @(posedge clk) begin
        s0_op_q  <= s0_op_d;
        s0_col_q <= s0_col_d;
        s1_op_q  <= s1_op_d;
    end

endmodule

// File: tb/tb_cms_row_bank.sv
// Scoreboard bench for cms_row_bank, built small (4 rows, 16 cols, 4-bit counts,
// 2-bit epoch) so saturation and epoch wrap are reachable in a short run.
module tb_cms_row_bank;

    localparam int NR = 4;
    localparam int NC = 16;
    localparam int CS = 4;
    localparam int EW = 2;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_op;
    logic [15:0] in_col;
    logic        clr_req;
    logic        clr_busy;
    logic        out_valid;
    logic        out_op;
    logic [15:0] out_cnt;
    logic [3:0]  out_min;

    typedef struct {
        logic        op;
        logic [15:0] cnt;
        logic [3:0]  mn;
        int          stamp;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy;
    int   rdy_hi;
    int   extra;

    cms_row_bank #(
        .NUM_ROWS (NR),
        .COLS     (NC),
        .CNT_SIZE (CS),
        .EPOCH_W  (EW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_col    (in_col),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .out_valid (out_valid),
        .out_op    (out_op),
        .out_cnt   (out_cnt),
        .out_min   (out_min)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] pk(input int a, input int b, input int c, input int d);
        return {4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    function automatic logic [3:0] exp_min(input logic [15:0] v);
        logic [3:0] m;
        m = v[3:0];
        for (int r = 1; r < 4; r++) begin
            if (v[r*4 +: 4] < m) m = v[r*4 +: 4];
        end
`ifdef CMS_MIN_REDUCE_EN
        return m;
`else
        return 4'd0;
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got out_cnt=%h with no expected entry (cycle %0d)", out_cnt, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("out_op",  {31'd0, out_op}, {31'd0, mon_e.op});
                chk("out_cnt", {16'd0, out_cnt}, {16'd0, mon_e.cnt});
                chk("out_min", {28'd0, out_min}, {28'd0, mon_e.mn});
                chk("latency", cyc - mon_e.stamp, 3);
            end
        end
    end

    task automatic send(input logic op, input logic [15:0] cols, input logic [15:0] ecnt, input logic clr);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_col   = cols;
        clr_req  = clr;
        chk("accept", {31'd0, in_ready}, 1);
        if (in_ready) begin
            e.op    = op;
            e.cnt   = ecnt;
            e.mn    = exp_min(ecnt);
            e.stamp = cyc;
            sb_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            clr_req  = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge clk);
            in_valid = 1'b0;
            n++;
        end
        chk("sb_drain", sb_q.size(), 0);
    endtask

    task automatic wait_ready(input int max);
        int n;
        n = 0;
        while (!in_ready && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("ready_up", {31'd0, in_ready}, 1);
    endtask

    // Called at the first negedge after the clear was accepted.
    task automatic meas_busy(input logic absorb, output int nbusy, output int nrdy);
        chk("ready_drop", {31'd0, in_ready}, 0);
        nbusy = 0;
        nrdy  = 0;
        while (clr_busy && nbusy < 100) begin
            nbusy++;
            if (in_ready) nrdy++;
            clr_req = absorb && (nbusy == 5);
            @(negedge clk);
        end
        clr_req = 1'b0;
    endtask

    task automatic do_clear(input logic absorb, output int nbusy, output int nrdy);
        @(negedge clk);
        in_valid = 1'b0;
        clr_req  = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        meas_busy(absorb, nbusy, nrdy);
    endtask

    localparam logic U = 1'b0;
    localparam logic Q = 1'b1;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_op    = 1'b0;
        in_col   = '0;
        clr_req  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_op",    {31'd0, out_op}, 0);
        chk("rst_out_cnt",   {16'd0, out_cnt}, 0);
        chk("rst_out_min",   {28'd0, out_min}, 0);
        chk("rst_clr_busy",  {31'd0, clr_busy}, 0);
        chk("rst_in_ready",  {31'd0, in_ready}, 0);
        rst = 1'b0;
        wait_ready(60);

        // fresh bank reads zero
        send(Q, pk(5, 5, 5, 5), pk(0, 0, 0, 0), 1'b0);
        idle(1);
        drain();

        // back-to-back updates, then a query right behind them
        for (int i = 1; i <= 5; i++) send(U, pk(7, 0, 0, 0), pk(i, i, i, i), 1'b0);
        send(Q, pk(7, 0, 0, 0), pk(5, 5, 5, 5), 1'b0);
        idle(1);
        drain();

        // interleaved columns and a one-cycle gap
        send(U, pk(4, 4, 4, 4), pk(1, 1, 1, 1), 1'b0);
        send(U, pk(6, 6, 6, 6), pk(1, 1, 1, 1), 1'b0);
        send(U, pk(4, 4, 4, 4), pk(2, 2, 2, 2), 1'b0);
        send(U, pk(9, 9, 9, 9), pk(1, 1, 1, 1), 1'b0);
        idle(1);
        send(U, pk(9, 9, 9, 9), pk(2, 2, 2, 2), 1'b0);
        idle(1);
        drain();

        // saturation at 15
        for (int i = 1; i <= 17; i++) begin
            send(U, pk(11, 11, 11, 11), pk(i > 15 ? 15 : i, i > 15 ? 15 : i, i > 15 ? 15 : i, i > 15 ? 15 : i), 1'b0);
        end
        send(Q, pk(11, 11, 11, 11), pk(15, 15, 15, 15), 1'b0);
        idle(1);
        drain();

        // build pre-counts {4,2,4,9} at cols {1,2,1,3}, spilling extras into col 15
        for (int i = 1; i <= 9; i++) begin
            send(U, pk(i <= 4 ? 1 : 15, i <= 2 ? 2 : 15, i <= 4 ? 1 : 15, 3),
                    pk(i <= 4 ? i : i - 4, i <= 2 ? i : i - 2, i <= 4 ? i : i - 4, i), 1'b0);
        end
        send(U, pk(1, 2, 1, 3), pk(5, 3, 5, 10), 1'b0);
        send(Q, pk(15, 15, 15, 3), pk(5, 7, 5, 10), 1'b0);
        idle(1);
        drain();

        // clear with a same-cycle request processed pre-clear (epoch 0 -> 1)
        send(U, pk(10, 10, 10, 10), pk(1, 1, 1, 1), 1'b0);
        send(U, pk(10, 10, 10, 10), pk(2, 2, 2, 2), 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        clr_req  = 1'b0;
        meas_busy(1'b0, busy, rdy_hi);
        chk("clr1_busy_le4", {31'd0, (busy >= 1 && busy <= 4)}, 1);
        drain();
        send(Q, pk(10, 10, 10, 10), pk(0, 0, 0, 0), 1'b0);
        send(Q, pk(7, 0, 0, 0), pk(0, 0, 0, 0), 1'b0);
        send(U, pk(10, 10, 10, 10), pk(1, 1, 1, 1), 1'b0);
        idle(1);
        drain();

        // clears 2 and 3: no sweep
        do_clear(1'b0, busy, rdy_hi);
        chk("clr2_busy_le4", {31'd0, (busy >= 1 && busy <= 4)}, 1);
        send(Q, pk(10, 10, 10, 10), pk(0, 0, 0, 0), 1'b0);
        idle(1);
        drain();
        do_clear(1'b0, busy, rdy_hi);
        chk("clr3_busy_le4", {31'd0, (busy >= 1 && busy <= 4)}, 1);
        send(U, pk(12, 12, 12, 12), pk(1, 1, 1, 1), 1'b0);
        send(U, pk(12, 12, 12, 12), pk(2, 2, 2, 2), 1'b0);
        idle(1);
        drain();

        // clear 4 wraps the epoch: one drain cycle plus a 16-column sweep,
        // with a second clr_req during the sweep that must be ignored
        do_clear(1'b1, busy, rdy_hi);
        chk("wrap_busy_len", busy, 17);
        chk("wrap_ready_low", rdy_hi, 0);
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (clr_busy) extra++;
        end
        chk("absorb_no_reclear", extra, 0);
        send(Q, pk(11, 11, 11, 11), pk(0, 0, 0, 0), 1'b0);
        send(Q, pk(1, 2, 1, 3), pk(0, 0, 0, 0), 1'b0);
        send(Q, pk(12, 12, 12, 12), pk(0, 0, 0, 0), 1'b0);
        send(U, pk(12, 12, 12, 12), pk(1, 1, 1, 1), 1'b0);
        idle(1);
        drain();

        // reset with requests in flight: results dropped, sweep re-run
        send(U, pk(13, 13, 13, 13), pk(1, 1, 1, 1), 1'b0);
        send(U, pk(13, 13, 13, 13), pk(2, 2, 2, 2), 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        sb_q.delete();
        @(negedge clk);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 0);
        chk("mid_rst_in_ready",  {31'd0, in_ready}, 0);
        chk("mid_rst_clr_busy",  {31'd0, clr_busy}, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_ready(60);
        send(Q, pk(13, 13, 13, 13), pk(0, 0, 0, 0), 1'b0);
        send(Q, pk(4, 4, 4, 4), pk(0, 0, 0, 0), 1'b0);
        send(U, pk(13, 13, 13, 13), pk(1, 1, 1, 1), 1'b0);
        idle(1);
        drain();
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
